// File: rtl/host_wg_dispatcher_pkg.sv
// Shared widths, descriptor field offsets and FSM encoding for the host workgroup dispatcher.
package host_wg_dispatcher_pkg;

  localparam int unsigned FIELD_W    = 32;
  localparam int unsigned DESC_WIDTH = 320;

  localparam int unsigned KD_GRID_X     = 0;
  localparam int unsigned KD_GRID_Y     = 1;
  localparam int unsigned KD_GRID_Z     = 2;
  localparam int unsigned KD_WF_SIZE    = 3;
  localparam int unsigned KD_WG_SIZE    = 4;
  localparam int unsigned KD_META_BASE  = 5;
  localparam int unsigned KD_PDS_SIZE   = 6;
  localparam int unsigned KD_SGPR_USAGE = 7;
  localparam int unsigned KD_VGPR_USAGE = 8;
  localparam int unsigned KD_PDS_BASE   = 9;

  localparam int unsigned WG_ID_WIDTH     = 15;
  localparam int unsigned NUM_WF_WIDTH    = 5;
  localparam int unsigned WF_SIZE_WIDTH   = 7;
  localparam int unsigned WG_SIZE_X_WIDTH = 10;
  localparam int unsigned MEM_ADDR_WIDTH  = 32;
  localparam int unsigned VGPR_ID_WIDTH   = 10;
  localparam int unsigned SGPR_ID_WIDTH   = 10;
  localparam int unsigned LDS_ID_WIDTH    = 10;
  localparam int unsigned GDS_ID_WIDTH    = 10;

  localparam int unsigned KSIZE_W = 3 * WG_SIZE_X_WIDTH;
  localparam int unsigned VRES_W  = VGPR_ID_WIDTH + 1;
  localparam int unsigned SRES_W  = SGPR_ID_WIDTH + 1;
  localparam int unsigned LRES_W  = LDS_ID_WIDTH + 1;
  localparam int unsigned GRES_W  = GDS_ID_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [FIELD_W-1:0] kd_field(input logic [DESC_WIDTH-1:0] desc,
                                                  input int unsigned idx);
    return desc[idx*FIELD_W +: FIELD_W];
  endfunction

endpackage

// File: rtl/host_wg_dispatcher_if.sv
// Kernel descriptor, host_req and host_rsp channels between the dispatcher (master) and host/GPU (slave).
interface host_wg_dispatcher_if;
  import host_wg_dispatcher_pkg::*;

  logic                      knl_valid_i;
  logic                      knl_ready_o;
  logic [DESC_WIDTH-1:0]     knl_desc_i;

  logic                      host_req_valid_i;
  logic                      host_req_ready_o;
  logic [WG_ID_WIDTH-1:0]    host_req_wg_id_i;
  logic [NUM_WF_WIDTH-1:0]   host_req_num_wf_i;
  logic [WF_SIZE_WIDTH-1:0]  host_req_wf_size_i;
  logic [KSIZE_W-1:0]        host_req_kernel_size_3d_i;
  logic [MEM_ADDR_WIDTH-1:0] host_req_start_pc_i;
  logic [MEM_ADDR_WIDTH-1:0] host_req_pds_baseaddr_i;
  logic [MEM_ADDR_WIDTH-1:0] host_req_csr_knl_i;
  logic [MEM_ADDR_WIDTH-1:0] host_req_gds_baseaddr_i;
  logic [VRES_W-1:0]         host_req_vgpr_size_total_i;
  logic [SRES_W-1:0]         host_req_sgpr_size_total_i;
  logic [LRES_W-1:0]         host_req_lds_size_total_i;
  logic [GRES_W-1:0]         host_req_gds_size_total_i;
  logic [VRES_W-1:0]         host_req_vgpr_size_per_wf_i;
  logic [SRES_W-1:0]         host_req_sgpr_size_per_wf_i;

  logic                      host_rsp_valid_o;
  logic                      host_rsp_ready_i;
  logic [WG_ID_WIDTH-1:0]    host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o;

  logic                      knl_done_o;
  logic                      rsp_err_o;

  modport master (
    input  knl_valid_i, knl_desc_i, host_req_ready_o, host_rsp_valid_o,
           host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
    output knl_ready_o, host_req_valid_i, host_req_wg_id_i, host_req_num_wf_i,
           host_req_wf_size_i, host_req_kernel_size_3d_i, host_req_start_pc_i,
           host_req_pds_baseaddr_i, host_req_csr_knl_i, host_req_gds_baseaddr_i,
           host_req_vgpr_size_total_i, host_req_sgpr_size_total_i, host_req_lds_size_total_i,
           host_req_gds_size_total_i, host_req_vgpr_size_per_wf_i, host_req_sgpr_size_per_wf_i,
           host_rsp_ready_i, knl_done_o, rsp_err_o
  );

  modport slave (
    output knl_valid_i, knl_desc_i, host_req_ready_o, host_rsp_valid_o,
           host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
    input  knl_ready_o, host_req_valid_i, host_req_wg_id_i, host_req_num_wf_i,
           host_req_wf_size_i, host_req_kernel_size_3d_i, host_req_start_pc_i,
           host_req_pds_baseaddr_i, host_req_csr_knl_i, host_req_gds_baseaddr_i,
           host_req_vgpr_size_total_i, host_req_sgpr_size_total_i, host_req_lds_size_total_i,
           host_req_gds_size_total_i, host_req_vgpr_size_per_wf_i, host_req_sgpr_size_per_wf_i,
           host_rsp_ready_i, knl_done_o, rsp_err_o
  );
endinterface

// File: rtl/host_wg_dispatcher.sv
// Walks the grid of one kernel descriptor, issuing one host_req per workgroup,
// and pulses knl_done_o once every issued workgroup has reported completion.
module host_wg_dispatcher
  import host_wg_dispatcher_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter logic [31:0] START_PC     = 32'h8000_0000,
  parameter int unsigned LDS_PER_WG   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  host_wg_dispatcher_if.master  bus
);

  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  state_e              r_state, w_state_nxt;
  logic [31:0]         r_gx, r_gy, r_gz, r_wf_size, r_wg_size, r_meta, r_pds_size, r_pds_base;
  logic [VRES_W-1:0]   r_vgpr_usage, r_vgpr_total;
  logic [SRES_W-1:0]   r_sgpr_usage, r_sgpr_total;
  logic [31:0]         r_total, r_stride, r_pds_cur, r_blk, r_completed;
  logic [INF_W-1:0]    r_inflight, w_inflight_nxt;
  logic                r_valid, r_knl_ready, r_rsp_ready, r_done, r_err;
  logic                w_accept, w_fire, w_rsp_ok, w_last, w_valid_nxt;
  logic [31:0]         w_total, w_stride;

  // Next state, inflight bookkeeping and the registered-valid decision
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = bus.knl_valid_i && r_knl_ready;
    w_fire         = r_valid && bus.host_req_ready_o;
    w_rsp_ok       = bus.host_rsp_valid_o && (r_inflight != '0);
    w_total        = r_gx * r_gy * r_gz;
    w_stride       = r_pds_size * r_wf_size * r_wg_size;
    w_last         = (r_blk == (r_total - 32'd1));
    w_inflight_nxt = r_inflight;

    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP: w_state_nxt = (w_total == 32'd0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (w_fire && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_completed == r_total) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    if (w_fire && !w_rsp_ok)      w_inflight_nxt = r_inflight + INF_W'(1);
    else if (!w_fire && w_rsp_ok) w_inflight_nxt = r_inflight - INF_W'(1);

    w_valid_nxt = (w_state_nxt == ST_ISSUE) && (w_inflight_nxt < INF_W'(MAX_INFLIGHT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Descriptor latch, per-kernel setup and issue/completion counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gx <= '0; r_gy <= '0; r_gz <= '0; r_wf_size <= '0; r_wg_size <= '0;
      r_meta <= '0; r_pds_size <= '0; r_pds_base <= '0;
      r_vgpr_usage <= '0; r_sgpr_usage <= '0; r_vgpr_total <= '0; r_sgpr_total <= '0;
      r_total <= '0; r_stride <= '0; r_pds_cur <= '0; r_blk <= '0; r_completed <= '0;
      r_inflight <= '0; r_valid <= 1'b0; r_knl_ready <= 1'b0; r_rsp_ready <= 1'b0;
      r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_knl_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_ready <= 1'b1;
      r_valid     <= w_valid_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
      r_inflight  <= w_inflight_nxt;
      if (bus.host_rsp_valid_o && (r_inflight == '0)) r_err <= 1'b1;

      if (w_accept) begin
        r_gx         <= kd_field(bus.knl_desc_i, KD_GRID_X);
        r_gy         <= kd_field(bus.knl_desc_i, KD_GRID_Y);
        r_gz         <= kd_field(bus.knl_desc_i, KD_GRID_Z);
        r_wf_size    <= kd_field(bus.knl_desc_i, KD_WF_SIZE);
        r_wg_size    <= kd_field(bus.knl_desc_i, KD_WG_SIZE);
        r_meta       <= kd_field(bus.knl_desc_i, KD_META_BASE);
        r_pds_size   <= kd_field(bus.knl_desc_i, KD_PDS_SIZE);
        r_sgpr_usage <= SRES_W'(kd_field(bus.knl_desc_i, KD_SGPR_USAGE));
        r_vgpr_usage <= VRES_W'(kd_field(bus.knl_desc_i, KD_VGPR_USAGE));
        r_pds_base   <= kd_field(bus.knl_desc_i, KD_PDS_BASE);
      end

      if (r_state == ST_SETUP) begin
        r_total      <= w_total;
        r_stride     <= w_stride;
        r_pds_cur    <= r_pds_base;
        r_blk        <= '0;
        r_completed  <= '0;
        r_vgpr_total <= VRES_W'(r_wg_size) * r_vgpr_usage;
        r_sgpr_total <= SRES_W'(r_wg_size) * r_sgpr_usage;
      end else begin
        if (w_fire) begin
          r_blk     <= r_blk + 32'd1;
          r_pds_cur <= r_pds_cur + r_stride;
        end
        if (w_rsp_ok) r_completed <= r_completed + 32'd1;
      end
    end
  end

  assign bus.knl_ready_o                 = r_knl_ready;
  assign bus.host_req_valid_i            = r_valid;
  assign bus.host_req_wg_id_i            = r_blk[WG_ID_WIDTH-1:0];
  assign bus.host_req_num_wf_i           = NUM_WF_WIDTH'(r_wg_size);
  assign bus.host_req_wf_size_i          = WF_SIZE_WIDTH'(r_wf_size);
  assign bus.host_req_kernel_size_3d_i   = {WG_SIZE_X_WIDTH'(r_gz), WG_SIZE_X_WIDTH'(r_gy),
                                            WG_SIZE_X_WIDTH'(r_gx)};
  assign bus.host_req_start_pc_i         = START_PC;
  assign bus.host_req_pds_baseaddr_i     = r_pds_cur;
  assign bus.host_req_csr_knl_i          = r_meta;
  assign bus.host_req_gds_baseaddr_i     = '0;
  assign bus.host_req_vgpr_size_total_i  = r_vgpr_total;
  assign bus.host_req_sgpr_size_total_i  = r_sgpr_total;
  assign bus.host_req_lds_size_total_i   = LRES_W'(LDS_PER_WG);
  assign bus.host_req_gds_size_total_i   = '0;
  assign bus.host_req_vgpr_size_per_wf_i = r_vgpr_usage;
  assign bus.host_req_sgpr_size_per_wf_i = r_sgpr_usage;
  assign bus.host_rsp_ready_i            = r_rsp_ready;
  assign bus.knl_done_o                  = r_done;
  assign bus.rsp_err_o                   = r_err;

endmodule

// File: tb/tb_host_wg_dispatcher.sv
// Directed bench for host_wg_dispatcher: a per-cycle vector table for a 2-WG kernel,
// then hand sequences for backpressure, inflight limit, coincident rsp, empty grid and reset abort.
module tb_host_wg_dispatcher;
  import host_wg_dispatcher_pkg::*;

  localparam int unsigned MAXI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  host_wg_dispatcher_if bus();

  host_wg_dispatcher #(.MAX_INFLIGHT(MAXI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0, n_fire = 0, n_done = 0;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic        exp_valid;
    logic        chk_pay;
    logic [31:0] exp_wg;
    logic [31:0] exp_pds;
    logic        exp_done;
    logic        exp_kr;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: count a fire if valid&&ready going into the edge, sample outputs 1ns after it
  task automatic tick();
    if (bus.host_req_valid_i === 1'b1 && bus.host_req_ready_o === 1'b1) n_fire++;
    @(posedge clk);
    #1;
    if (bus.knl_done_o === 1'b1) n_done++;
  endtask

  task automatic send_kernel(input logic [31:0] gx, gy, gz, wf, wg, meta, pds_sz, sgpr, vgpr, pds_base);
    logic [DESC_WIDTH-1:0] d;
    int k;
    d = '0;
    d[KD_GRID_X*32 +: 32]     = gx;
    d[KD_GRID_Y*32 +: 32]     = gy;
    d[KD_GRID_Z*32 +: 32]     = gz;
    d[KD_WF_SIZE*32 +: 32]    = wf;
    d[KD_WG_SIZE*32 +: 32]    = wg;
    d[KD_META_BASE*32 +: 32]  = meta;
    d[KD_PDS_SIZE*32 +: 32]   = pds_sz;
    d[KD_SGPR_USAGE*32 +: 32] = sgpr;
    d[KD_VGPR_USAGE*32 +: 32] = vgpr;
    d[KD_PDS_BASE*32 +: 32]   = pds_base;
    k = 0;
    while (bus.knl_ready_o !== 1'b1 && k < 20) begin tick(); k++; end
    check("knl_ready_before_send", 32'(bus.knl_ready_o), 32'd1);
    bus.knl_desc_i  = d;
    bus.knl_valid_i = 1'b1;
    tick();
    bus.knl_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int d0;
    d0 = n_done;
    for (int i = 0; i < max_cyc && n_done == d0; i++) tick();
    check(name, 32'(n_done - d0), 32'd1);
  endtask

  task automatic pulse_rsp();
    bus.host_rsp_valid_o = 1'b1;
    tick();
    bus.host_rsp_valid_o = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, d0;
    // Kernel 1: grid 2x1x1, wg 4, wf 16, pds_size 0x100 -> stride 0x4000
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'h9000_0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 32'h9000_4000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b1};

    bus.knl_valid_i = 1'b0;
    bus.knl_desc_i  = '0;
    bus.host_req_ready_o = 1'b0;
    bus.host_rsp_valid_o = 1'b0;
    bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o = '0;

    // Reset state
    tick(); tick();
    check("rst_valid",     32'(bus.host_req_valid_i), 32'd0);
    check("rst_knl_ready", 32'(bus.knl_ready_o),      32'd0);
    check("rst_rsp_ready", 32'(bus.host_rsp_ready_i), 32'd0);
    check("rst_done",      32'(bus.knl_done_o),       32'd0);
    check("rst_err",       32'(bus.rsp_err_o),        32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_knl_ready", 32'(bus.knl_ready_o),      32'd1);
    check("post_rst_rsp_ready", 32'(bus.host_rsp_ready_i), 32'd1);

    // Test 1: table-driven walk of a 2-WG kernel
    send_kernel(32'd2, 32'd1, 32'd1, 32'd16, 32'd4, 32'h1234_0000, 32'h100, 32'd8, 32'd12, 32'h9000_0000);
    for (int i = 0; i < 8; i++) begin
      bus.host_req_ready_o = tbl[i].rdy;
      bus.host_rsp_valid_o = tbl[i].rsp;
      tick();
      check($sformatf("t1_valid[%0d]", i),     32'(bus.host_req_valid_i), 32'(tbl[i].exp_valid));
      check($sformatf("t1_done[%0d]", i),      32'(bus.knl_done_o),       32'(tbl[i].exp_done));
      check($sformatf("t1_knl_ready[%0d]", i), 32'(bus.knl_ready_o),      32'(tbl[i].exp_kr));
      if (tbl[i].chk_pay) begin
        check($sformatf("t1_wg_id[%0d]", i),  32'(bus.host_req_wg_id_i),        tbl[i].exp_wg);
        check($sformatf("t1_pds[%0d]", i),    bus.host_req_pds_baseaddr_i,      tbl[i].exp_pds);
        check("t1_num_wf",      32'(bus.host_req_num_wf_i),           32'd4);
        check("t1_wf_size",     32'(bus.host_req_wf_size_i),          32'd16);
        check("t1_ksize3d",     32'(bus.host_req_kernel_size_3d_i),   {2'b0, 10'd1, 10'd1, 10'd2});
        check("t1_start_pc",    bus.host_req_start_pc_i,              32'h8000_0000);
        check("t1_csr_knl",     bus.host_req_csr_knl_i,               32'h1234_0000);
        check("t1_vgpr_total",  32'(bus.host_req_vgpr_size_total_i),  32'd48);
        check("t1_sgpr_total",  32'(bus.host_req_sgpr_size_total_i),  32'd32);
        check("t1_vgpr_per_wf", 32'(bus.host_req_vgpr_size_per_wf_i), 32'd12);
        check("t1_sgpr_per_wf", 32'(bus.host_req_sgpr_size_per_wf_i), 32'd8);
        check("t1_lds_total",   32'(bus.host_req_lds_size_total_i),   32'd128);
        check("t1_gds_total",   32'(bus.host_req_gds_size_total_i),   32'd0);
        check("t1_gds_base",    bus.host_req_gds_baseaddr_i,          32'd0);
      end
    end
    bus.host_rsp_valid_o = 1'b0;

    // Test 2: ready held low 5 cycles, payload stable, one fire
    send_kernel(32'd1, 32'd1, 32'd1, 32'd8, 32'd2, 32'h5555_0000, 32'h10, 32'd4, 32'd6, 32'hA000_0000);
    bus.host_req_ready_o = 1'b0;
    tick();
    check("t2_valid_rise", 32'(bus.host_req_valid_i), 32'd1);
    f0 = n_fire;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_hold_valid[%0d]", i), 32'(bus.host_req_valid_i), 32'd1);
      check($sformatf("t2_hold_wg[%0d]", i),    32'(bus.host_req_wg_id_i), 32'd0);
      check($sformatf("t2_hold_pds[%0d]", i),   bus.host_req_pds_baseaddr_i, 32'hA000_0000);
      check($sformatf("t2_hold_vgpr[%0d]", i),  32'(bus.host_req_vgpr_size_total_i), 32'd12);
    end
    bus.host_req_ready_o = 1'b1;
    tick();
    bus.host_req_ready_o = 1'b0;
    check("t2_valid_after_fire", 32'(bus.host_req_valid_i), 32'd0);
    check("t2_fire_count", 32'(n_fire - f0), 32'd1);
    pulse_rsp();
    wait_done(6, "t2_done");

    // Test 3: inflight limit of 2 with no responses
    send_kernel(32'd4, 32'd1, 32'd1, 32'd16, 32'd1, 32'h0, 32'd1, 32'd1, 32'd1, 32'h0000_0100);
    bus.host_req_ready_o = 1'b1;
    f0 = n_fire;
    repeat (6) tick();
    check("t3_fires_before_stall", 32'(n_fire - f0), 32'd2);
    check("t3_valid_stalled", 32'(bus.host_req_valid_i), 32'd0);
    pulse_rsp();
    check("t3_valid_after_rsp", 32'(bus.host_req_valid_i), 32'd1);
    check("t3_wg_id_3rd", 32'(bus.host_req_wg_id_i), 32'd2);
    check("t3_pds_3rd", bus.host_req_pds_baseaddr_i, 32'h0000_0120);
    tick();
    check("t3_fires_total", 32'(n_fire - f0), 32'd3);
    check("t3_valid_restall", 32'(bus.host_req_valid_i), 32'd0);

    // Test 4: response coincident with the last fire leaves inflight unchanged
    pulse_rsp();
    check("t4_valid_4th", 32'(bus.host_req_valid_i), 32'd1);
    check("t4_wg_id_4th", 32'(bus.host_req_wg_id_i), 32'd3);
    pulse_rsp();
    bus.host_req_ready_o = 1'b0;
    check("t4_fires_total", 32'(n_fire - f0), 32'd4);
    check("t4_valid_drain", 32'(bus.host_req_valid_i), 32'd0);
    d0 = n_done;
    repeat (3) tick();
    check("t4_no_early_done", 32'(n_done - d0), 32'd0);
    pulse_rsp();
    wait_done(6, "t4_done");
    check("t4_no_err", 32'(bus.rsp_err_o), 32'd0);

    // Test 5: empty grid completes two cycles after accept; idle rsp flags error
    f0 = n_fire;
    send_kernel(32'd0, 32'd3, 32'd1, 32'd16, 32'd4, 32'h0, 32'h100, 32'd1, 32'd1, 32'h0);
    check("t5_done_setup", 32'(bus.knl_done_o), 32'd0);
    tick();
    check("t5_done_pulse", 32'(bus.knl_done_o), 32'd1);
    tick();
    check("t5_done_low", 32'(bus.knl_done_o), 32'd0);
    check("t5_knl_ready", 32'(bus.knl_ready_o), 32'd1);
    check("t5_no_fire", 32'(n_fire - f0), 32'd0);
    check("t5_err_before", 32'(bus.rsp_err_o), 32'd0);
    pulse_rsp();
    check("t5_err_set", 32'(bus.rsp_err_o), 32'd1);
    tick();
    check("t5_err_sticky", 32'(bus.rsp_err_o), 32'd1);

    // Test 6: reset mid-ISSUE aborts, then a fresh kernel restarts at wg 0
    send_kernel(32'd3, 32'd1, 32'd1, 32'd4, 32'd1, 32'h0, 32'd2, 32'd1, 32'd1, 32'hB000_0000);
    bus.host_req_ready_o = 1'b0;
    tick();
    check("t6_valid_pre_rst", 32'(bus.host_req_valid_i), 32'd1);
    d0 = n_done;
    rst_n = 1'b0;
    tick();
    check("t6_valid_rst", 32'(bus.host_req_valid_i), 32'd0);
    check("t6_err_rst",   32'(bus.rsp_err_o),        32'd0);
    check("t6_kr_rst",    32'(bus.knl_ready_o),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_kr_release", 32'(bus.knl_ready_o), 32'd1);
    check("t6_no_done", 32'(n_done - d0), 32'd0);
    send_kernel(32'd1, 32'd1, 32'd1, 32'd4, 32'd1, 32'h0, 32'd2, 32'd1, 32'd1, 32'hC000_0000);
    tick();
    check("t6_valid_new",  32'(bus.host_req_valid_i), 32'd1);
    check("t6_wg_id_new",  32'(bus.host_req_wg_id_i), 32'd0);
    check("t6_pds_new",    bus.host_req_pds_baseaddr_i, 32'hC000_0000);
    bus.host_req_ready_o = 1'b1;
    tick();
    bus.host_req_ready_o = 1'b0;
    pulse_rsp();
    wait_done(6, "t6_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
